// File: rtl/fu_pkg.sv
// Shared types and width helpers for the FU writeback arbiter slice.
package fu_pkg;

    localparam int unsigned INST_ID_BITS = 6;
    localparam int unsigned PRN_BITS     = 6;
    localparam int unsigned MAX_OPERANDS = 3;
    localparam int unsigned DATA_BITS    = 64;

    // One buffered FU result as it travels from FU to writeback port.
    typedef struct packed {
        logic [INST_ID_BITS-1:0]                   inst_id;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]     prn;
        logic [MAX_OPERANDS-1:0][DATA_BITS-1:0]    data;
        logic [MAX_OPERANDS-1:0]                   slot_valid;
    } wb_rec_t;

    // Index width that stays >= 1 even for a single-entry range.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fu_wb_arbiter_if.sv
// FU result inputs, writeback port outputs and status bundled for the arbiter.
interface fu_wb_arbiter_if #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned NUM_WB = 2
);
    import fu_pkg::*;

    logic                                                  flush;
    logic [NUM_FU-1:0]                                     fu_out_valid;
    logic [NUM_FU-1:0][INST_ID_BITS-1:0]                   fu_out_inst_id;
    logic [NUM_FU-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]     fu_out_prn;
    logic [NUM_FU-1:0][MAX_OPERANDS-1:0][DATA_BITS-1:0]    fu_out_data;
    logic [NUM_FU-1:0][MAX_OPERANDS-1:0]                   fu_out_slot_valid;
    logic [NUM_FU-1:0]                                     fu_stall;
    logic [NUM_WB-1:0]                                     wb_valid;
    logic [NUM_WB-1:0]                                     wb_ready;
    logic [NUM_WB-1:0][INST_ID_BITS-1:0]                   wb_inst_id;
    logic [NUM_WB-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]     wb_prn;
    logic [NUM_WB-1:0][MAX_OPERANDS-1:0][DATA_BITS-1:0]    wb_data;
    logic [NUM_WB-1:0][MAX_OPERANDS-1:0]                   wb_slot_valid;
    logic                                                  overflow_err;

    modport master (
        input  flush, fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data,
               fu_out_slot_valid, wb_ready,
        output fu_stall, wb_valid, wb_inst_id, wb_prn, wb_data, wb_slot_valid,
               overflow_err
    );

    modport slave (
        output flush, fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data,
               fu_out_slot_valid, wb_ready,
        input  fu_stall, wb_valid, wb_inst_id, wb_prn, wb_data, wb_slot_valid,
               overflow_err
    );

endinterface

// File: rtl/fu_out_fifo.sv
// Per-FU result buffer; flush empties it, pushes into a full buffer are dropped and flagged.
module fu_out_fifo
    import fu_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2,
    parameter type         rec_t     = wb_rec_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  rec_t push_rec,
    input  logic pop,
    input  logic flush,
    output rec_t head_rec,
    output logic empty,
    output logic full,
    output logic overflow_c
);

    localparam int unsigned PTR_W = idx_bits(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    rec_t             mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full       = (count == CNT_W'(BUF_DEPTH));
    assign empty      = (count == '0);
    assign do_push    = push & ~full & ~flush;
    assign do_pop     = pop & ~empty & ~flush;
    // A full buffer rejects the push even when it pops in the same cycle.
    assign overflow_c = push & full & ~flush;
    assign head_rec   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= push_rec;
    end

endmodule

// File: rtl/fu_wb_arbiter.sv
// Writeback stage: buffers NUM_FU result streams and grants heads round-robin onto NUM_WB ports.
module fu_wb_arbiter
    import fu_pkg::*;
#(
    parameter int unsigned NUM_FU    = 4,
    parameter int unsigned NUM_WB    = 2,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    fu_wb_arbiter_if.master    bus
);

    localparam int unsigned FU_W = idx_bits(NUM_FU);

    logic [FU_W-1:0]   rr_ptr;
    logic [FU_W-1:0]   rr_nxt;
    wb_rec_t           push_rec [NUM_FU];
    wb_rec_t           head_rec [NUM_FU];
    logic [NUM_FU-1:0] empty;
    logic [NUM_FU-1:0] full;
    logic [NUM_FU-1:0] ovf;
    logic [NUM_FU-1:0] pop;
    logic [NUM_WB-1:0] gnt_vld;
    logic [FU_W-1:0]   gnt_idx [NUM_WB];
    logic              overflow_err;

    logic [NUM_WB-1:0][INST_ID_BITS-1:0]                wb_inst_id_c;
    logic [NUM_WB-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  wb_prn_c;
    logic [NUM_WB-1:0][MAX_OPERANDS-1:0][DATA_BITS-1:0] wb_data_c;
    logic [NUM_WB-1:0][MAX_OPERANDS-1:0]                wb_slot_valid_c;

    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            push_rec[i].inst_id    = bus.fu_out_inst_id[i];
            push_rec[i].prn        = bus.fu_out_prn[i];
            push_rec[i].data       = bus.fu_out_data[i];
            push_rec[i].slot_valid = bus.fu_out_slot_valid[i];
        end
    end

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
        fu_out_fifo #(
            .BUF_DEPTH (BUF_DEPTH),
            .rec_t     (wb_rec_t)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push       (bus.fu_out_valid[i]),
            .push_rec   (push_rec[i]),
            .pop        (pop[i]),
            .flush      (bus.flush),
            .head_rec   (head_rec[i]),
            .empty      (empty[i]),
            .full       (full[i]),
            .overflow_c (ovf[i])
        );
    end

    // Scan from rr_ptr and hand the first NUM_WB non-empty FIFOs to ports in order.
    always_comb begin
        logic [NUM_FU-1:0] taken;
        logic [FU_W:0]     s;
        logic [FU_W-1:0]   idx;
        taken   = '0;
        gnt_vld = '0;
        s       = '0;
        idx     = '0;
        for (int unsigned p = 0; p < NUM_WB; p++) gnt_idx[p] = '0;
        for (int unsigned p = 0; p < NUM_WB; p++) begin
            for (int unsigned k = 0; k < NUM_FU; k++) begin
                s = {1'b0, rr_ptr} + (FU_W+1)'(k);
                if (s >= (FU_W+1)'(NUM_FU)) s = s - (FU_W+1)'(NUM_FU);
                idx = s[FU_W-1:0];
                if (!gnt_vld[p] && !empty[idx] && !taken[idx]) begin
                    gnt_vld[p] = 1'b1;
                    gnt_idx[p] = idx;
                    taken[idx] = 1'b1;
                end
            end
        end
    end

    // Pop accepted heads; the pointer moves past the FU on the highest accepted port.
    always_comb begin
        logic            any_acc;
        logic [FU_W-1:0] last;
        pop     = '0;
        any_acc = 1'b0;
        last    = '0;
        for (int unsigned p = 0; p < NUM_WB; p++) begin
            if (gnt_vld[p] && bus.wb_ready[p]) begin
                pop[gnt_idx[p]] = 1'b1;
                any_acc         = 1'b1;
                last            = gnt_idx[p];
            end
        end
        rr_nxt = rr_ptr;
        if (any_acc && !bus.flush) begin
            rr_nxt = (last == FU_W'(NUM_FU - 1)) ? '0 : last + FU_W'(1);
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NUM_WB; p++) begin
            wb_inst_id_c[p]    = '0;
            wb_prn_c[p]        = '0;
            wb_data_c[p]       = '0;
            wb_slot_valid_c[p] = '0;
            if (gnt_vld[p]) begin
                wb_inst_id_c[p]    = head_rec[gnt_idx[p]].inst_id;
                wb_prn_c[p]        = head_rec[gnt_idx[p]].prn;
                wb_data_c[p]       = head_rec[gnt_idx[p]].data;
                wb_slot_valid_c[p] = head_rec[gnt_idx[p]].slot_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            overflow_err <= 1'b0;
        end else begin
            rr_ptr <= rr_nxt;
            if (|ovf) overflow_err <= 1'b1;
        end
    end

    assign bus.fu_stall      = full;
    assign bus.wb_valid      = gnt_vld;
    assign bus.wb_inst_id    = wb_inst_id_c;
    assign bus.wb_prn        = wb_prn_c;
    assign bus.wb_data       = wb_data_c;
    assign bus.wb_slot_valid = wb_slot_valid_c;
    assign bus.overflow_err  = overflow_err;

endmodule

// File: doc/fu_wb_arbiter.md
Name: fu_wb_arbiter

Overview:
- Parametrised writeback stage that collects results from NUM_FU functional units and drives NUM_WB writeback ports toward the PRF and ROB.
- Each FU output is buffered in a per-FU FIFO. Credit-style backpressure (fu_stall) goes back to each FU.
- Heads are granted round-robin across FUs; order is preserved within a single FU.
- Adds backpressure, multi-port writeback and flush, which the single-FU output bundle lacks.

Parameters:
- NUM_FU, 4, number of functional units feeding the block
- NUM_WB, 2, number of writeback ports (1 <= NUM_WB <= NUM_FU)
- BUF_DEPTH, 2, entries per FU FIFO (power of two, >= 2)
- INST_ID_BITS, 6, instruction ID width
- PRN_BITS, 6, physical register number width
- MAX_OPERANDS, 3, result slots per instruction

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  discard all buffered results
- fu_out_valid  in  [NUM_FU]  FU result valid
- fu_out_inst_id  in  [NUM_FU][INST_ID_BITS]  result instruction ID
- fu_out_prn  in  [NUM_FU][MAX_OPERANDS][PRN_BITS]  destination PRNs
- fu_out_data  in  [NUM_FU][MAX_OPERANDS][64]  result data
- fu_out_slot_valid  in  [NUM_FU][MAX_OPERANDS]  per-slot write enable
- fu_stall  out  [NUM_FU]  FIFO full; the FU must hold its result
- wb_valid  out  [NUM_WB]  writeback port valid
- wb_ready  in  [NUM_WB]  consumer accepts port this cycle
- wb_inst_id  out  [NUM_WB][INST_ID_BITS]  instruction ID
- wb_prn  out  [NUM_WB][MAX_OPERANDS][PRN_BITS]  PRNs
- wb_data  out  [NUM_WB][MAX_OPERANDS][64]  data
- wb_slot_valid  out  [NUM_WB][MAX_OPERANDS]  slot write enables
- overflow_err  out  1  sticky: push attempted into a full FIFO

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset: all FIFO counts and pointers 0, rr_ptr = 0, overflow_err = 0.
  - Consequently wb_valid = 0 and fu_stall = 0 in the cycle after reset.
  - Reset overrides flush and all pushes.
- Push: on a clk edge with fu_out_valid[i] = 1 and FIFO i not full, the record {inst_id, prn, data, slot_valid} is written at the tail.
  - The record is visible at the FIFO head one cycle later (min latency: FU valid at cycle t, wb_valid at t+1).
- fu_stall[i] = (count[i] == BUF_DEPTH). It is combinational from registered count and never depends on wb_ready.
- Push while full: the record is dropped and overflow_err is set. This holds even if the same FIFO pops that cycle.
  - overflow_err is cleared only by rst.
- Grant: scan FUs in order rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - The first NUM_WB non-empty FIFOs are assigned to wb ports 0..NUM_WB-1 in scan order.
  - Unassigned ports have wb_valid = 0, with don't-care payload driven as 0.
  - Assignment and wb_valid must not depend on wb_ready.
- Pop: a FIFO pops on the edge where its assigned port has wb_valid & wb_ready. Unaccepted heads remain and are re-offered next cycle.
- Each FU occupies at most one port per cycle, so no FIFO ever pops twice in a cycle.
- rr_ptr update: if any port accepted, rr_ptr = (index of FU granted on the highest accepted port + 1) mod NUM_FU. Otherwise rr_ptr holds.
- Simultaneous push and pop on a non-full FIFO: count is unchanged and data order is preserved.
- Flush: on the edge, all FIFOs are emptied and same-cycle pushes are dropped. rr_ptr and overflow_err hold.
  - wb_valid = 0 in the following cycle.
  - Accepts in the flush cycle are irrelevant; nothing is written back after flush.
- Pointer wrap: FIFO rd/wr pointers are log2(BUF_DEPTH) bits and wrap naturally. count is log2(BUF_DEPTH)+1 bits.

Decomposition:
- Shared package fu_pkg:
  - wb_rec_t struct {inst_id, prn[MAX_OPERANDS], data[MAX_OPERANDS], slot_valid[MAX_OPERANDS]}
  - clog2-based width constants
- Sub-module fu_out_fifo:
  - One instance per FU; parameters BUF_DEPTH and rec type.
  - Ports: push, push_rec, pop, flush, head_rec, empty, full, overflow pulse.
- Arbitration and rr_ptr logic live in fu_wb_arbiter.

Test Plan:
- Reset, then FU0 valid at cycle 1 with inst_id 5, prn[0] = 12, data[0] = 0xDEAD, wb_ready = 11 -> wb_valid[0] = 1 at cycle 2 carrying id 5; wb_valid[1] = 0; FIFO empty at cycle 3.
- FUs 0-3 all push in one cycle, wb_ready = 11, rr_ptr = 0 -> cycle+1: ports carry FU0, FU1; cycle+2: FU2, FU3; rr_ptr ends at 0.
- FU1 pushes ids 7, 8, 9 on back-to-back cycles with wb_ready = 00 -> fu_stall[1] = 1 after 2 pushes; a third push while stalled sets overflow_err; after wb_ready returns, order 7, 8 appears and 9 is never seen.
- wb_ready[0] = 0, wb_ready[1] = 1 with FU0 and FU2 heads -> FU2 pops, FU0 is re-offered next cycle, rr_ptr = 3.
- Buffer 3 results, assert flush for one cycle while FU3 pushes -> wb_valid = 00 the next cycle, all counts 0, overflow_err unchanged.
- Assert rst while FIFOs are full and flush = 1 -> next cycle wb_valid = 0, fu_stall = 0, overflow_err = 0, rr_ptr = 0.
